signal_delay_meter: RTL and testbench
=====================================

Name: signal_delay_meter

Overview:
- Measures, in clk_Signal cycles, the delay between a rising edge on a reference signal and the matching rising edge on its returned (delayed) copy.
- Sits at the far end of the signal delay path. Produces a raw cycle count plus a saturated 3-bit delay code that can feed directly into the existing 3-bit tap-select input of the signal delay line.
- Used for loop-back calibration of the delay chain and for measuring external path delay.

Parameters:
- CNT_W, 8, width of the delay counter and Delay_Count; max measurable delay = 2^CNT_W-1 cycles.
- CODE_MAX, 7, saturation value for Delay_Code; must be less than 8.

Ports:
- clk_Signal  input  1  signal unit clock; sole clock.
- Rst  input  1  synchronous, active-high reset.
- Enable  input  1  measurement enable; low aborts and holds the block in IDLE.
- Ref_In  input  1  reference signal; its rising edge starts a measurement.
- Echo_In  input  1  delayed copy; its rising edge ends a measurement.
- Delay_Count  output  CNT_W  last measured delay in cycles.
- Delay_Code  output  3  min(Delay_Count, CODE_MAX); updated together with Delay_Count.
- Meas_Valid  output  1  one-cycle pulse when a new Delay_Count is loaded.
- Timeout  output  1  one-cycle pulse when no echo arrives within 2^CNT_W-1 cycles.
- Busy  output  1  high while in COUNT.

Behaviour:
- Ref_In and Echo_In are each registered once (prev-sample flop). A rising edge at clock edge n means the sample at n is 1 and the sample at n-1 is 0. Inputs are already synchronous to clk_Signal; there is no synchroniser inside the block.
- Reset (Rst=1 at a clock edge): state=IDLE, counter=0, Delay_Count=0, Delay_Code=0, Meas_Valid=0, Timeout=0, Busy=0, prev samples=0. Reset wins over every other event.
- States: IDLE, COUNT, HOLDOFF.
- IDLE:
  - Ref edge with Enable=1 -> COUNT at the next edge, counter=0.
  - Echo edges in IDLE are ignored.
  - If a Ref edge and an Echo edge occur at the same edge: Delay_Count=0 and Meas_Valid pulses on the next cycle. The block goes straight to HOLDOFF and never enters COUNT.
- COUNT:
  - Busy=1; counter increments by 1 each cycle.
  - Echo edge k cycles after the Ref edge -> Delay_Count=k, Delay_Code=min(k, CODE_MAX), Meas_Valid=1 for exactly one cycle (the cycle after the Echo edge edge), then HOLDOFF.
  - Further Ref edges while in COUNT are ignored; they do not restart the count.
  - Counter reaches 2^CNT_W-1 with no echo -> Timeout pulses for one cycle, Delay_Count=2^CNT_W-1 (saturated), Delay_Code=CODE_MAX, Meas_Valid stays 0, then HOLDOFF. An echo arriving in the same cycle as the counter reaching 2^CNT_W-1 counts as a valid measurement, not a timeout.
- HOLDOFF: remains here until Ref_In=0 and Echo_In=0 are both sampled, then IDLE. This prevents a long reference pulse from re-triggering.
- Enable=0 in any state -> IDLE at the next edge. No pulse is generated; Delay_Count/Delay_Code keep their last values.
- Delay_Count and Delay_Code change only on valid completion, on timeout, or on reset.
- Meas_Valid and Timeout are never high in the same cycle.

Decomposition:
- Shared package:
  - state enum (IDLE, COUNT, HOLDOFF);
  - CODE_W=3 constant, shared with the delay line's tap-select width.
- One natural sub-module: sig_edge_detect (1-bit registered rising-edge detector with synchronous reset), instantiated twice, once for Ref_In and once for Echo_In.

Test Plan:
- Reset then Ref rises at edge 10, Echo rises at edge 15 -> Delay_Count=5, Delay_Code=5, Meas_Valid high exactly one cycle, Busy high edges 11-15.
- Loop-back through the delay line with Delay_Num=0..7 (Echo = delay line output of Ref) -> Delay_Count equals the configured delay in every case. Then Echo delay 12 cycles -> Delay_Count=12, Delay_Code=7.
- Ref and Echo rise at the same edge -> Delay_Count=0, Meas_Valid pulse, Busy never asserted.
- CNT_W=4, Ref edge with no Echo -> Timeout pulse 15 cycles after the Ref edge, Delay_Count=15, Delay_Code=7, Meas_Valid=0. A second Ref rise while Ref is held high produces no new measurement until both inputs return low.
- Ref edge, extra Ref pulse at +3, Echo at +6 -> Delay_Count=6 (the count is not restarted).
- Rst=1 or Enable=0 mid-COUNT at +3, Echo at +6 -> no Meas_Valid. After Rst: all outputs 0. After Enable drop: previous Delay_Count retained.

Source files
------------

// File: rtl/signal_delay_meter_pkg.sv
// signal_delay_meter_pkg
//   Types and constants shared by the signal delay meter and its sub-module.
//   - meas_state_t : measurement FSM states (IDLE, COUNT, HOLDOFF)
//   - CODE_W       : width of the delay code. It matches the tap-select
//                    input of the signal delay line.
//   - sat_code()   : clamps a cycle count to a code limit.
package signal_delay_meter_pkg;

    localparam int CODE_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        HOLDOFF = 2'd2
    } meas_state_t;

    // min(value, limit), truncated to the tap-select width. The limit is
    // always below 2**CODE_W, so the truncation never loses information.
    function automatic logic [CODE_W-1:0] sat_code(input int value, input int limit);
        return (value > limit) ? CODE_W'(limit) : CODE_W'(value);
    endfunction

endpackage

// File: rtl/signal_delay_meter_edge.sv
// sig_edge_detect
//   1-bit rising-edge detector with a synchronous, active-high reset.
//   The input is already synchronous to clk_Signal. A rising edge is reported
//   at the clock edge where the current sample is 1 and the previous sample
//   (held in the flop) is 0.
//   Ports:
//     clk_Signal : clock
//     Rst        : synchronous active-high reset; clears the previous sample
//     sig        : input signal
//     rise       : high while sig=1 and the previous sample was 0
module sig_edge_detect (
    input  logic clk_Signal,
    input  logic Rst,
    input  logic sig,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk_Signal) begin
        if (Rst) begin
            prev <= 1'b0;
        end else begin
            prev <= sig;
        end
    end

    assign rise = sig & ~prev;

endmodule

// File: rtl/signal_delay_meter.sv
// signal_delay_meter
//   Measures the delay, in clk_Signal cycles, from a rising edge on Ref_In to
//   the matching rising edge on its returned copy Echo_In. The block reports a
//   raw count and a saturated 3-bit code that can drive the tap-select input
//   of the signal delay line directly.
//   Ports:
//     clk_Signal  : clock
//     Rst         : synchronous active-high reset
//     Enable      : low forces IDLE (aborts a measurement without a pulse)
//     Ref_In      : reference signal; its rising edge starts a measurement
//     Echo_In     : delayed copy; its rising edge ends a measurement
//     Delay_Count : last measured delay (2**CNT_W-1 after a timeout)
//     Delay_Code  : min(Delay_Count, CODE_MAX)
//     Meas_Valid  : one-cycle pulse when a new measurement is loaded
//     Timeout     : one-cycle pulse when no echo arrives in 2**CNT_W-1 cycles
//     Busy        : high while counting
//   CODE_MAX must be below 8 (it has to fit the 3-bit tap select).
module signal_delay_meter
    import signal_delay_meter_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int CODE_MAX = 7
) (
    input  logic              clk_Signal,
    input  logic              Rst,
    input  logic              Enable,
    input  logic              Ref_In,
    input  logic              Echo_In,
    output logic [CNT_W-1:0]  Delay_Count,
    output logic [CODE_W-1:0] Delay_Code,
    output logic              Meas_Valid,
    output logic              Timeout,
    output logic              Busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    meas_state_t      state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] count_next;
    logic             ref_rise;
    logic             echo_rise;

    sig_edge_detect u_ref_edge (
        .clk_Signal (clk_Signal),
        .Rst        (Rst),
        .sig        (Ref_In),
        .rise       (ref_rise)
    );

    sig_edge_detect u_echo_edge (
        .clk_Signal (clk_Signal),
        .Rst        (Rst),
        .sig        (Echo_In),
        .rise       (echo_rise)
    );

    // The counter holds the number of edges since the Ref edge, minus one.
    // An echo seen at this edge therefore measures counter+1 cycles.
    assign count_next = counter + 1'b1;

    always_ff @(posedge clk_Signal) begin
        if (Rst) begin
            state       <= IDLE;
            counter     <= '0;
            Delay_Count <= '0;
            Delay_Code  <= '0;
            Meas_Valid  <= 1'b0;
            Timeout     <= 1'b0;
        end else begin
            Meas_Valid <= 1'b0;
            Timeout    <= 1'b0;
            if (!Enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (ref_rise) begin
                            if (echo_rise) begin
                                // Zero-cycle path: complete at once and skip COUNT.
                                Delay_Count <= '0;
                                Delay_Code  <= '0;
                                Meas_Valid  <= 1'b1;
                                state       <= HOLDOFF;
                            end else begin
                                counter <= '0;
                                state   <= COUNT;
                            end
                        end
                    end
                    COUNT: begin
                        counter <= count_next;
                        // An echo that arrives as the counter reaches its
                        // maximum is a valid measurement, so it is checked first.
                        if (echo_rise) begin
                            Delay_Count <= count_next;
                            Delay_Code  <= sat_code(int'(count_next), CODE_MAX);
                            Meas_Valid  <= 1'b1;
                            state       <= HOLDOFF;
                        end else if (count_next == CNT_MAX) begin
                            Delay_Count <= CNT_MAX;
                            Delay_Code  <= CODE_W'(CODE_MAX);
                            Timeout     <= 1'b1;
                            state       <= HOLDOFF;
                        end
                    end
                    HOLDOFF: begin
                        // Wait for both lines to go quiet. This stops a long
                        // reference pulse from re-arming the meter.
                        if (!Ref_In && !Echo_In) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign Busy = (state == COUNT);

endmodule

// File: tb/tb_signal_delay_meter.sv
// tb_signal_delay_meter
//   Drives two meters (CNT_W=8 and CNT_W=4) from the same stimulus. Each
//   scenario is described by a few numbers: the echo delay d, the pulse
//   lengths, and an optional abort point. The expected outputs for every cycle
//   are derived arithmetically from those numbers.
module tb_signal_delay_meter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, ref_s, echo_s;

    logic [7:0] cnt8;
    logic [2:0] code8;
    logic       mv8, to8, busy8;
    logic [3:0] cnt4;
    logic [2:0] code4;
    logic       mv4, to4, busy4;

    signal_delay_meter #(.CNT_W(8), .CODE_MAX(7)) dut8 (
        .clk_Signal (clk),
        .Rst        (rst),
        .Enable     (en),
        .Ref_In     (ref_s),
        .Echo_In    (echo_s),
        .Delay_Count(cnt8),
        .Delay_Code (code8),
        .Meas_Valid (mv8),
        .Timeout    (to8),
        .Busy       (busy8)
    );

    signal_delay_meter #(.CNT_W(4), .CODE_MAX(7)) dut4 (
        .clk_Signal (clk),
        .Rst        (rst),
        .Enable     (en),
        .Ref_In     (ref_s),
        .Echo_In    (echo_s),
        .Delay_Count(cnt4),
        .Delay_Code (code4),
        .Meas_Valid (mv4),
        .Timeout    (to4),
        .Busy       (busy4)
    );

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned exp_cnt8 = 0;
    int unsigned exp_cnt4 = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference for one meter with maximum count m, observed after edge i of a
    // scenario. abort_kind: 0 none, 1 reset at edge a, 2 enable low at edge a.
    // A measurement ends at edge min(d, m): it is valid if d <= m and a
    // timeout otherwise. An abort at or before that edge suppresses the pulse.
    task automatic check_one(input string name, input int i, input int d,
                             input int abort_kind, input int a, input int m,
                             inout int unsigned exp_cnt,
                             input logic [31:0] cnt, input logic [31:0] code,
                             input logic [31:0] mv, input logic [31:0] to,
                             input logic [31:0] busy);
        bit is_valid;
        bit aborted;
        int evt;
        int stop;
        is_valid = (d <= m);
        evt      = is_valid ? d : m;
        aborted  = (abort_kind != 0) && (a <= evt);
        stop     = aborted ? a : evt;
        if (abort_kind == 1 && i == a) exp_cnt = 0;
        else if (!aborted && i == evt) exp_cnt = is_valid ? d : m;
        check_eq({name, ".busy"},    busy, 32'(i < stop));
        check_eq({name, ".valid"},   mv,   32'(!aborted && is_valid && i == evt));
        check_eq({name, ".timeout"}, to,   32'(!aborted && !is_valid && i == evt));
        check_eq({name, ".count"},   cnt,  exp_cnt);
        check_eq({name, ".code"},    code, (exp_cnt > 7) ? 32'd7 : exp_cnt);
    endtask

    // ---------------- driver ----------------
    // mode: 0 plain, 1 extra Ref pulse at +3, 2 Ref dips and re-rises during
    // holdoff while Echo stays high, 3 reset at edge a, 4 Enable low at edge a.
    function automatic logic ref_wave(input int mode, input int i, input int r);
        case (mode)
            1:       return (i == 0) || (i == 3);
            2:       return (i < r) || (i > r && i < r + 3);
            default: return i < r;
        endcase
    endfunction

    function automatic logic echo_wave(input int mode, input int i, input int d, input int r, input int e);
        if (mode == 2) return (i >= d) && (i < r + 5);
        return (i >= d) && (i < d + e);
    endfunction

    task automatic check_both(input int i, input int mode, input int d, input int a);
        int ak;
        ak = (mode == 3) ? 1 : (mode == 4) ? 2 : 0;
        check_one("w8", i, d, ak, a, 255, exp_cnt8, 32'(cnt8), 32'(code8), 32'(mv8), 32'(to8), 32'(busy8));
        check_one("w4", i, d, ak, a, 15,  exp_cnt4, 32'(cnt4), 32'(code4), 32'(mv4), 32'(to4), 32'(busy4));
    endtask

    task automatic run_scn(input int mode, input int d, input int r, input int e, input int a);
        int last;
        int len;
        if (mode == 2) last = r + 4;
        else if (mode == 1) last = (d + e - 1 > 3) ? d + e - 1 : 3;
        else last = (r - 1 > d + e - 1) ? r - 1 : d + e - 1;
        len = last + 5;   // trailing quiet edges let both meters leave HOLDOFF
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i > 0) check_both(i - 1, mode, d, a);
            ref_s  = ref_wave(mode, i, r);
            echo_s = echo_wave(mode, i, d, r, e);
            rst    = (mode == 3 && i == a);
            en     = !(mode == 4 && i == a);
        end
        @(negedge clk);
        check_both(len - 1, mode, d, a);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int mode, d, r, e, a;
        rst = 1'b1; en = 1'b1; ref_s = 1'b0; echo_s = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst.w8.count", 32'(cnt8), 0);
        check_eq("rst.w8.code",  32'(code8), 0);
        check_eq("rst.w8.valid", 32'(mv8), 0);
        check_eq("rst.w8.timeout", 32'(to8), 0);
        check_eq("rst.w8.busy",  32'(busy8), 0);
        check_eq("rst.w4.count", 32'(cnt4), 0);
        check_eq("rst.w4.code",  32'(code4), 0);
        check_eq("rst.w4.valid", 32'(mv4), 0);
        check_eq("rst.w4.timeout", 32'(to4), 0);
        check_eq("rst.w4.busy",  32'(busy4), 0);
        rst = 1'b0;

        // Directed cases.
        run_scn(0, 5, 3, 2, 0);
        for (int k = 0; k < 8; k++) run_scn(0, k, 2, 2, 0);   // loop-back copies, delays 0..7
        run_scn(0, 12, 2, 2, 0);
        run_scn(0, 15, 2, 2, 0);    // echo as the 4-bit counter reaches its maximum
        run_scn(0, 16, 2, 2, 0);    // 4-bit meter times out, 8-bit meter measures 16
        run_scn(1, 6, 1, 2, 0);
        run_scn(3, 6, 1, 2, 3);
        run_scn(0, 9, 2, 2, 0);
        run_scn(4, 6, 1, 2, 3);
        run_scn(2, 20, 25, 0, 0);   // timeout, then Ref re-rises while Echo is still high
        run_scn(2, 4, 8, 0, 0);
        run_scn(0, 22, 3, 2, 0);    // echo arrives in IDLE for the 4-bit meter

        // Random cases.
        for (int n = 0; n < 60; n++) begin
            mode = $urandom_range(0, 4);
            d    = (mode == 0) ? $urandom_range(0, 30) : $urandom_range(5, 30);
            e    = $urandom_range(1, 4);
            r    = (mode == 0) ? $urandom_range(1, 35) : 1;
            if (mode == 2) r = d + 2 + $urandom_range(0, 5);
            a    = (mode >= 3) ? $urandom_range(2, d - 2) : 0;
            run_scn(mode, d, r, e, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
